l1_cmd_sequencer: RTL and testbench

L1_CMD_SEQUENCER -- requirements
Module: l1_cmd_sequencer

---
 rtl/l1_cmd_sequencer.sv | 170 +++++++++++++++++
 tb/tb_l1_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cmd_sequencer.sv
// L1 command sequencer: merges a 4-deep trace command FIFO with L2 snoop requests
// and issues one command at a time to the L1 data cache, with fairness and a watchdog.
module l1_cmd_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_cmd,
    input  logic [59:0] in_addr,
    input  logic        snoop_valid,
    input  logic        snoop_kind,
    input  logic [59:0] snoop_addr,
    output logic        snoop_ready,
    output logic        cache_write,
    output logic [2:0]  cache_cmd,
    output logic [59:0] cache_addr,
    input  logic        cache_processing,
    output logic        busy,
    output logic [31:0] issued_count,
    output logic [15:0] drop_count,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        ERROR      = 3'd4
    } state_t;

    state_t      state_r;
    logic [62:0] fifo_mem_r [0:3];
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [2:0]  count_r;
    logic [1:0]  fair_r;
    logic [7:0]  wd_r;
    logic        cache_write_r;
    logic        snoop_ready_r;
    logic [2:0]  cache_cmd_r;
    logic [59:0] cache_addr_r;
    logic [31:0] issued_count_r;
    logic [15:0] drop_count_r;
    logic        timeout_err_r;

    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        in_ready_s;
    logic        push_s;
    logic        pop_s;
    logic        can_select_s;
    logic        trace_owed_s;
    logic        sel_snoop_s;
    logic [62:0] head_s;
    logic        head_drop_s;

    // Selection, FIFO handshake and fairness decode
    always_comb begin
        fifo_full_s  = (count_r == 3'd4);
        fifo_empty_s = (count_r == 3'd0);
        in_ready_s   = !fifo_full_s && (state_r != ERROR);
        push_s       = in_valid && in_ready_s;
        head_s       = fifo_mem_r[rd_ptr_r];
        head_drop_s  = (head_s[62:60] > 3'd4);
        can_select_s = (state_r == IDLE) && !cache_processing;
        trace_owed_s = (fair_r == 2'd3) && !fifo_empty_s;
        sel_snoop_s  = can_select_s && snoop_valid && !trace_owed_s;
        pop_s        = can_select_s && !sel_snoop_s && !fifo_empty_s;
    end

    // Trace FIFO storage and pointers; data words are not reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {in_cmd, in_addr};
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r <= count_r + {2'b00, push_s} - {2'b00, pop_s};
        end
    end

    // Main sequencer FSM with registered cache-side outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            fair_r         <= 2'd0;
            wd_r           <= 8'd0;
            cache_write_r  <= 1'b0;
            snoop_ready_r  <= 1'b0;
            cache_cmd_r    <= 3'd0;
            cache_addr_r   <= 60'd0;
            issued_count_r <= 32'd0;
            drop_count_r   <= 16'd0;
            timeout_err_r  <= 1'b0;
        end else begin
            cache_write_r <= 1'b0;
            snoop_ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sel_snoop_s) begin
                        snoop_ready_r <= 1'b1;
                        cache_write_r <= 1'b1;
                        cache_cmd_r   <= snoop_kind ? 3'd4 : 3'd2;
                        cache_addr_r  <= snoop_addr;
                        state_r       <= ISSUE;
                        // Only snoops that bypass waiting trace work count towards fairness
                        fair_r        <= fifo_empty_s ? 2'd0 : fair_r + 2'd1;
                    end else if (pop_s) begin
                        fair_r <= 2'd0;
                        if (head_drop_s) begin
                            if (drop_count_r != 16'hFFFF) begin
                                drop_count_r <= drop_count_r + 16'd1;
                            end
                        end else begin
                            cache_write_r <= 1'b1;
                            cache_cmd_r   <= head_s[62:60];
                            cache_addr_r  <= head_s[59:0];
                            state_r       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    issued_count_r <= issued_count_r + 32'd1;
                    state_r        <= WAIT_START;
                end
                WAIT_START: begin
                    // A cache that finishes within one cycle is seen as done in WAIT_DONE
                    wd_r    <= 8'd0;
                    state_r <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!cache_processing) begin
                        state_r <= IDLE;
                    end else if (wd_r == 8'd254) begin
                        wd_r          <= wd_r + 8'd1;
                        timeout_err_r <= 1'b1;
                        state_r       <= ERROR;
                    end else begin
                        wd_r <= wd_r + 8'd1;
                    end
                end
                ERROR: begin
                    state_r <= ERROR;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_s;
    assign busy         = (state_r != IDLE);
    assign snoop_ready  = snoop_ready_r;
    assign cache_write  = cache_write_r;
    assign cache_cmd    = cache_cmd_r;
    assign cache_addr   = cache_addr_r;
    assign issued_count = issued_count_r;
    assign drop_count   = drop_count_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_l1_cmd_sequencer.sv
// Directed self-checking bench for l1_cmd_sequencer; issues are logged on the falling edge.
module tb_l1_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_cmd;
    logic [59:0] in_addr;
    logic        snoop_valid;
    logic        snoop_kind;
    logic [59:0] snoop_addr;
    logic        snoop_ready;
    logic        cache_write;
    logic [2:0]  cache_cmd;
    logic [59:0] cache_addr;
    logic        cache_processing;
    logic        busy;
    logic [31:0] issued_count;
    logic [15:0] drop_count;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] log_q[$];

    l1_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
        .snoop_valid(snoop_valid), .snoop_kind(snoop_kind), .snoop_addr(snoop_addr),
        .snoop_ready(snoop_ready), .cache_write(cache_write), .cache_cmd(cache_cmd),
        .cache_addr(cache_addr), .cache_processing(cache_processing), .busy(busy),
        .issued_count(issued_count), .drop_count(drop_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Record every issued command as {snoop_ready, cmd, addr}
    always @(negedge clk) begin
        if (cache_write) log_q.push_back({snoop_ready, cache_cmd, cache_addr});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_cmd = 3'd0; in_addr = 60'd0;
        snoop_valid = 1'b0; snoop_kind = 1'b0; snoop_addr = 60'd0;
        cache_processing = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if ({cache_write, snoop_ready, timeout_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %0b expected 000", {cache_write, snoop_ready, timeout_err}); end
        n_cmp++; if ({cache_cmd, cache_addr} !== 63'd0) begin n_err++; $display("FAIL reset_cmd_addr: got %0h expected 0", {cache_cmd, cache_addr}); end
        n_cmp++; if ({issued_count, drop_count} !== 48'd0) begin n_err++; $display("FAIL reset_counts: got %0h expected 0", {issued_count, drop_count}); end
    endtask

    task automatic test_latency();
        do_reset();
        in_valid = 1'b1; in_cmd = 3'd0; in_addr = 60'h123;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (cache_write !== 1'b0) begin n_err++; $display("FAIL lat_t1_write: got %0b expected 0", cache_write); end
        tick();
        n_cmp++; if (cache_write !== 1'b1) begin n_err++; $display("FAIL lat_t2_write: got %0b expected 1", cache_write); end
        n_cmp++; if (cache_cmd !== 3'd0) begin n_err++; $display("FAIL lat_cmd: got %0d expected 0", cache_cmd); end
        n_cmp++; if (cache_addr !== 60'h123) begin n_err++; $display("FAIL lat_addr: got %0h expected 123", cache_addr); end
        n_cmp++; if (snoop_ready !== 1'b0) begin n_err++; $display("FAIL lat_snoop_ready: got %0b expected 0", snoop_ready); end
        tick();
        n_cmp++; if (cache_write !== 1'b0) begin n_err++; $display("FAIL lat_t3_write: got %0b expected 0", cache_write); end
        n_cmp++; if (issued_count !== 32'd1) begin n_err++; $display("FAIL lat_issued: got %0d expected 1", issued_count); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lat_busy: got %0b expected 1", busy); end
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lat_back_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_fifo_full();
        bit got_ready = 1'b0;
        do_reset();
        cache_processing = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_cmd = 3'd1; in_addr = 60'h100 + 60'(i);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d: got %0b expected 1", i, in_ready); end
            tick();
        end
        in_addr = 60'h104;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_%0d: got %0b expected 0", i, in_ready); end
            tick();
        end
        cache_processing = 1'b0;
        for (int k = 0; k < 10 && !got_ready; k++) begin
            tick();
            if (in_ready === 1'b1) got_ready = 1'b1;
        end
        n_cmp++; if (!got_ready) begin n_err++; $display("FAIL full_release: got in_ready 0 expected 1 within 10 cycles"); end
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        n_cmp++; if (log_q.size() !== 5) begin n_err++; $display("FAIL full_issue_count: got %0d expected 5", log_q.size()); end
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i] !== {1'b0, 3'd1, 60'h100 + 60'(i)}) begin
                n_err++; $display("FAIL full_order_%0d: got %0h expected %0h", i, log_q[i], {1'b0, 3'd1, 60'h100 + 60'(i)});
            end
        end
    endtask

    task automatic test_fairness();
        logic [63:0] exp_e;
        bit is_trace [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int trace_idx = 0;
        do_reset();
        cache_processing = 1'b1;
        snoop_valid = 1'b1; snoop_kind = 1'b1; snoop_addr = 60'hABC;
        in_valid = 1'b1; in_cmd = 3'd0; in_addr = 60'h200;
        tick();
        in_cmd = 3'd1; in_addr = 60'h201;
        tick();
        in_valid = 1'b0;
        cache_processing = 1'b0;
        for (int k = 0; k < 34; k++) tick();
        snoop_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_cmp++; if (log_q.size() < 8) begin n_err++; $display("FAIL fair_issue_count: got %0d expected at least 8", log_q.size()); end
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            if (is_trace[i]) begin
                exp_e = {1'b0, 3'(trace_idx), 60'h200 + 60'(trace_idx)};
                trace_idx++;
            end else begin
                exp_e = {1'b1, 3'd4, 60'hABC};
            end
            n_cmp++;
            if (log_q[i] !== exp_e) begin n_err++; $display("FAIL fair_order_%0d: got %0h expected %0h", i, log_q[i], exp_e); end
        end
    endtask

    task automatic test_drop();
        do_reset();
        in_valid = 1'b1; in_cmd = 3'd6; in_addr = 60'h55;
        tick();
        in_cmd = 3'd7; in_addr = 60'h56;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_cmp++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL drop_count: got %0d expected 2", drop_count); end
        n_cmp++; if (issued_count !== 32'd0) begin n_err++; $display("FAIL drop_issued: got %0d expected 0", issued_count); end
        n_cmp++; if (log_q.size() !== 0) begin n_err++; $display("FAIL drop_no_write: got %0d writes expected 0", log_q.size()); end
        n_cmp++; if ({cache_cmd, cache_addr} !== 63'd0) begin n_err++; $display("FAIL drop_no_load: got %0h expected 0", {cache_cmd, cache_addr}); end
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        do_reset();
        in_valid = 1'b1; in_cmd = 3'd1; in_addr = 60'h77;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (cache_write === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL to_issue: got no cache_write expected one within 10 cycles"); end
        cache_processing = 1'b1;
        for (int k = 0; k < 256; k++) tick();
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_early: got %0b expected 0", timeout_err); end
        tick();
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_set: got %0b expected 1", timeout_err); end
        cache_processing = 1'b0;
        snoop_valid = 1'b1; snoop_kind = 1'b0; snoop_addr = 60'h99;
        in_valid = 1'b1; in_cmd = 3'd0; in_addr = 60'h88;
        for (int k = 0; k < 6; k++) tick();
        n_cmp++; if ({timeout_err, in_ready, busy} !== 3'b101) begin n_err++; $display("FAIL to_sticky: got %0b expected 101", {timeout_err, in_ready, busy}); end
        n_cmp++; if (log_q.size() !== 1) begin n_err++; $display("FAIL to_no_issue: got %0d writes expected 1", log_q.size()); end
        do_reset();
        n_cmp++; if ({timeout_err, in_ready, busy} !== 3'b010) begin n_err++; $display("FAIL to_cleared: got %0b expected 010", {timeout_err, in_ready, busy}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; in_cmd = 3'd0; in_addr = 60'h300;
        tick();
        in_valid = 1'b0;
        tick();
        cache_processing = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_addr = 60'h300 + 60'(i);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if ({busy, in_ready} !== 2'b11) begin n_err++; $display("FAIL mid_precond: got %0b expected 11", {busy, in_ready}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_q.delete();
        n_cmp++; if ({busy, in_ready, cache_write} !== 3'b010) begin n_err++; $display("FAIL mid_state: got %0b expected 010", {busy, in_ready, cache_write}); end
        n_cmp++; if ({issued_count, drop_count} !== 48'd0) begin n_err++; $display("FAIL mid_counts: got %0h expected 0", {issued_count, drop_count}); end
        cache_processing = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        n_cmp++; if (log_q.size() !== 0) begin n_err++; $display("FAIL mid_fifo_empty: got %0d writes expected 0", log_q.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fifo_full();
        test_fairness();
        test_drop();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
